prog_load_ctrl: RTL

- Boot-time sequencer between the UART byte receiver and the CPU instruction memory inside cpu_uart_top.
- Assembles received bytes into 32-bit words and writes CELL_NUMBERS words to consecutive imem addresses.
- Holds the CPU in reset while loading, then releases it to execute.
- Supports a reload command that returns the CPU to reset and restarts the program load.

---
 rtl/prog_load_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/prog_load_ctrl.sv
// Boot loader: packs UART bytes little-endian into 32-bit words, writes them to imem,
// holds the CPU in reset until the image is complete, and restarts the load on reload.
module prog_load_ctrl #(
    parameter int CELL_NUMBERS  = 64,
    parameter int ADDR_W        = 6,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);
    // Wide enough to hold RELEASE_DELAY+1, and at least one bit when the delay is 0.
    localparam int DW = $clog2(RELEASE_DELAY + 2);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELL_NUMBERS - 1);
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(CELL_NUMBERS);
    localparam logic [DW-1:0]     DLY      = DW'(RELEASE_DELAY);

    typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_t;

    state_t            state, state_d;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0][7:0]   asm_q;
    logic [DW-1:0]     drain_cnt;
    logic              accept, last_byte;

    // reload outranks everything, including a byte arriving in the same cycle
    assign accept    = (state == LOAD) && rx_valid && !reload;
    assign last_byte = accept && (byte_idx == 2'd3);
    assign loading   = (state == LOAD);
    assign cpu_rst_n = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) state <= LOAD;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (reload) begin
            state_d = LOAD;
        end else begin
            case (state)
                LOAD:    if (last_byte && (word_idx == LAST_IDX)) state_d = DRAIN;
                DRAIN:   if (drain_cnt == DLY) state_d = RUN;
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx   <= '0;
            word_idx   <= '0;
            asm_q      <= '0;
            drain_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_done  <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            if (reload) begin
                byte_idx   <= '0;
                word_idx   <= '0;
                asm_q      <= '0;
                drain_cnt  <= '0;
                word_count <= '0;
            end else begin
                if (accept) begin
                    asm_q[byte_idx] <= rx_byte;
                    byte_idx        <= byte_idx + 2'd1;
                end
                // Write path uses rx_byte directly so the word leaves one cycle after its last byte.
                if (last_byte) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_idx;
                    imem_wdata <= {rx_byte, asm_q[2], asm_q[1], asm_q[0]};
                    if (word_idx != LAST_IDX)  word_idx   <= word_idx + ADDR_W'(1);
                    if (word_count != CNT_MAX) word_count <= word_count + (ADDR_W + 1)'(1);
                end
                drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
                load_done <= (state == DRAIN) && (state_d == RUN);
            end
        end
    end
endmodule
